// File: rtl/sfp_norm_seq_if.sv
// Handshake bundle for sfp_norm_seq: psum vector in, normalized vector out,
// plus the debug abs-sum and busy flag.
interface sfp_norm_seq_if #(
    parameter int bw_psum = 20,
    parameter int col     = 8
);
    logic                      in_valid;
    logic                      in_ready;
    logic [col*bw_psum-1:0]    in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [col*bw_psum-1:0]    out_data;
    logic [bw_psum+3:0]        sum_out;
    logic                      busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, sum_out, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, sum_out, busy
    );
endinterface

// File: rtl/sfp_norm_seq.sv
// Self-timed normalizer: accumulates |x| over one psum vector, then divides
// every element by (sum >> shift) with a bit-serial restoring divider.
module sfp_norm_seq #(
    parameter int bw_psum = 20,
    parameter int col     = 8,
    parameter int shift   = 7
) (
    input  logic          clk,
    input  logic          reset,
    sfp_norm_seq_if.slave bus
);
    localparam int IW   = (col > 1) ? $clog2(col) : 1;
    localparam int BW_W = $clog2(bw_psum);
    localparam int SW   = bw_psum + 4;
    localparam int RW   = SW + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    localparam logic [IW-1:0]   LAST_IDX = IW'(col - 1);
    localparam logic [BW_W-1:0] LAST_BIT = BW_W'(bw_psum - 1);

    logic [1:0]             state_q, state_d;
    logic [col*bw_psum-1:0] data_q, data_d;
    logic [col*bw_psum-1:0] out_q, out_d;
    logic [SW-1:0]          sum_q, sum_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [BW_W-1:0]        bit_q, bit_d;
    logic [RW-1:0]          rem_q, rem_d;
    logic [bw_psum-1:0]     quo_q, quo_d;

    logic [bw_psum-1:0] x_elem;
    logic [bw_psum-1:0] abs_x;
    logic [bw_psum-1:0] quo_next;
    logic [bw_psum-1:0] result;
    logic [SW-1:0]      div_raw;
    logic [SW-1:0]      divisor;
    logic [RW-1:0]      trial;
    logic               fits;

    always_comb begin
        x_elem = '0;
        for (int i = 0; i < col; i++) begin
            if (idx_q == IW'(i)) x_elem = data_q[i*bw_psum +: bw_psum];
        end
    end

    // Unsigned magnitude, so the most negative element maps to 2^(bw_psum-1).
    assign abs_x    = x_elem[bw_psum-1] ? -x_elem : x_elem;
    assign div_raw  = sum_q >> shift;
    assign divisor  = (div_raw == '0) ? SW'(1) : div_raw;
    assign trial    = {rem_q[RW-2:0], abs_x[LAST_BIT - bit_q]};
    assign fits     = (trial >= {1'b0, divisor});
    assign quo_next = {quo_q[bw_psum-2:0], fits};
    assign result   = x_elem[bw_psum-1] ? -quo_next : quo_next;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        out_d   = out_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        bit_d   = bit_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    data_d  = bus.in_data;
                    sum_d   = '0;
                    idx_d   = '0;
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                sum_d = sum_q + SW'(abs_x);
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    bit_d   = '0;
                    rem_d   = '0;
                    quo_d   = '0;
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                rem_d = fits ? (trial - {1'b0, divisor}) : trial;
                quo_d = quo_next;
                bit_d = bit_q + 1'b1;
                if (bit_q == LAST_BIT) begin
                    for (int i = 0; i < col; i++) begin
                        if (idx_q == IW'(i)) out_d[i*bw_psum +: bw_psum] = result;
                    end
                    rem_d = '0;
                    quo_d = '0;
                    bit_d = '0;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = S_OUT;
                    end
                end
            end
            default: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            out_q   <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            bit_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            out_q   <= out_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            bit_q   <= bit_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_OUT);
    assign bus.busy      = (state_q == S_ACC) || (state_q == S_DIV);
    assign bus.out_data  = out_q;
    assign bus.sum_out   = sum_q;
endmodule

// File: tb/tb_sfp_norm_seq.sv
// Directed bench for sfp_norm_seq: hand-computed vectors, output hold,
// ignored input while busy, and asynchronous reset mid-divide.
module tb_sfp_norm_seq;
    localparam int BW  = 20;
    localparam int COL = 8;
    localparam int VW  = BW * COL;

    logic clk;
    logic reset;
    int   compareCount;
    int   failCount;

    sfp_norm_seq_if #(.bw_psum(BW), .col(COL)) bus ();

    sfp_norm_seq #(.bw_psum(BW), .col(COL), .shift(7)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [VW-1:0] packVec(input int e0, input int e1, input int e2, input int e3,
                                              input int e4, input int e5, input int e6, input int e7);
        logic [VW-1:0] v;
        v = {e7[BW-1:0], e6[BW-1:0], e5[BW-1:0], e4[BW-1:0],
             e3[BW-1:0], e2[BW-1:0], e1[BW-1:0], e0[BW-1:0]};
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        compareCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one vector across the accept edge; returns just after that edge.
    task automatic applyStimulus(input string tag, input logic [VW-1:0] v);
        checkOutput({tag, "_in_ready"}, VW'(bus.in_ready), VW'(1));
        bus.in_data  = v;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
    endtask

    // Counts edges from accept until out_valid, bounded; also captures sum_out after the ACC phase.
    task automatic waitOutput(output int cycles, output logic [BW+3:0] sumAcc);
        cycles = 0;
        sumAcc = '0;
        while (!bus.out_valid && cycles < 400) begin
            @(posedge clk);
            #1;
            cycles++;
            if (cycles == COL) sumAcc = bus.sum_out;
        end
    endtask

    task automatic runVector(input string tag, input logic [VW-1:0] v,
                             input logic [BW+3:0] expSum, input logic [VW-1:0] expOut);
        int            cycles;
        logic [BW+3:0] sumAcc;
        applyStimulus(tag, v);
        checkOutput({tag, "_busy"}, VW'(bus.busy), VW'(1));
        waitOutput(cycles, sumAcc);
        checkOutput({tag, "_latency"}, VW'(cycles), VW'(168));
        checkOutput({tag, "_sum_after_acc"}, VW'(sumAcc), VW'(expSum));
        checkOutput({tag, "_sum_out"}, VW'(bus.sum_out), VW'(expSum));
        checkOutput({tag, "_out_data"}, bus.out_data, expOut);
        checkOutput({tag, "_in_ready_low"}, VW'(bus.in_ready), VW'(0));
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checkOutput({tag, "_idle_after_hs"}, VW'(bus.in_ready), VW'(1));
        checkOutput({tag, "_valid_drop"}, VW'(bus.out_valid), VW'(0));
    endtask

    initial begin
        logic [VW-1:0] vecA, vecB, vecC, vecD;
        logic [VW-1:0] expA, expB, expC, expD;
        int            cycles;
        logic [BW+3:0] sumAcc;

        compareCount  = 0;
        failCount     = 0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        vecA = packVec(1000, 0, 0, 0, 0, 0, 0, 0);
        expA = packVec(142, 0, 0, 0, 0, 0, 0, 0);
        vecB = packVec(256, -256, 128, -128, 0, 0, 0, 0);
        expB = packVec(42, -42, 21, -21, 0, 0, 0, 0);
        vecC = packVec(100, 0, 0, 0, 0, 0, 0, 0);
        expC = packVec(100, 0, 0, 0, 0, 0, 0, 0);
        vecD = packVec(-524288, -524288, -524288, -524288, -524288, -524288, -524288, -524288);
        expD = packVec(-16, -16, -16, -16, -16, -16, -16, -16);

        reset = 1'b1;
        #12;
        checkOutput("rst_in_ready", VW'(bus.in_ready), VW'(1));
        checkOutput("rst_out_valid", VW'(bus.out_valid), VW'(0));
        checkOutput("rst_busy", VW'(bus.busy), VW'(0));
        checkOutput("rst_out_data", bus.out_data, '0);
        checkOutput("rst_sum_out", VW'(bus.sum_out), VW'(0));
        reset = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] vector A: single element 1000");
        runVector("A", vecA, 24'd1000, expA);
        $display("[TB] vector B: mixed signs");
        runVector("B", vecB, 24'd768, expB);
        $display("[TB] vector C: divisor forced to 1");
        runVector("C", vecC, 24'd100, expC);
        $display("[TB] vector D: all most-negative");
        runVector("D", vecD, 24'h400000, expD);
        checkOutput("D_elem0_hex", VW'(bus.out_data[BW-1:0]), VW'(20'hFFFF0));

        $display("[TB] hold test with ignored input pulse");
        applyStimulus("H", vecA);
        waitOutput(cycles, sumAcc);
        checkOutput("H_latency", VW'(cycles), VW'(168));
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                bus.in_valid = 1'b1;
                bus.in_data  = vecD;
            end else begin
                bus.in_valid = 1'b0;
                bus.in_data  = '0;
            end
            @(posedge clk);
            #1;
            checkOutput("H_valid_held", VW'(bus.out_valid), VW'(1));
            checkOutput("H_data_held", bus.out_data, expA);
            checkOutput("H_in_ready_low", VW'(bus.in_ready), VW'(0));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checkOutput("H_in_ready_after", VW'(bus.in_ready), VW'(1));
        checkOutput("H_busy_after", VW'(bus.busy), VW'(0));
        checkOutput("H_data_kept", bus.out_data, expA);
        checkOutput("H_sum_kept", VW'(bus.sum_out), VW'(1000));

        $display("[TB] async reset during divide");
        applyStimulus("R", vecB);
        for (int i = 0; i < COL + 50; i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("R_busy_before", VW'(bus.busy), VW'(1));
        #3;
        reset = 1'b1;
        #1;
        checkOutput("R_out_valid", VW'(bus.out_valid), VW'(0));
        checkOutput("R_busy", VW'(bus.busy), VW'(0));
        checkOutput("R_out_data", bus.out_data, '0);
        checkOutput("R_sum_out", VW'(bus.sum_out), VW'(0));
        checkOutput("R_in_ready", VW'(bus.in_ready), VW'(1));
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("R_idle_after", VW'(bus.in_ready), VW'(1));
        runVector("R2", vecA, 24'd1000, expA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end
endmodule
